// File: rtl/geofence_pkg.sv
// Shared widths, point layout and FSM encoding for the geofence frame feeder.
package geofence_pkg;
  localparam int PT_X_W    = 10;
  localparam int PT_Y_W    = 10;
  localparam int PT_R_W    = 11;
  localparam int FRAME_PTS = 6;
  localparam int CNT_W     = $clog2(FRAME_PTS + 1);

  localparam logic [1:0] ST_HOLD   = 2'd0;
  localparam logic [1:0] ST_STREAM = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;

  typedef struct packed {
    logic [PT_X_W-1:0] x;
    logic [PT_Y_W-1:0] y;
    logic [PT_R_W-1:0] r;
  } point_t;
endpackage

// File: rtl/geofence_frame_buf.sv
// Two-slot frame buffer: in-order fill with resync on start-of-frame, in-order drain.
module geofence_frame_buf
  import geofence_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_vld_i,
  input  logic             wr_sof_i,
  input  point_t           wr_pt_i,
  output logic             wr_rdy_o,
  output logic             err_sync_o,
  input  logic             rel_i,
  input  logic [CNT_W-1:0] rd_idx_i,
  output logic             rd_full_o,
  output point_t           rd_pt_o,
  output logic [TAG_W-1:0] rd_tag_o
);
  point_t [1:0][FRAME_PTS-1:0] mem_q;
  logic [1:0]             full_q, full_d;
  logic [1:0][TAG_W-1:0]  tag_q, tag_d;
  logic                   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       wr_cnt_q, wr_cnt_d, wr_idx;
  logic [TAG_W-1:0]       frame_cnt_q, frame_cnt_d;
  logic                   err_sync_q, acc, resync, commit;

  assign wr_rdy_o   = ~full_q[wr_ptr_q];
  assign acc        = wr_vld_i & wr_rdy_o;
  assign resync     = acc & wr_sof_i & (wr_cnt_q != '0);
  assign commit     = acc & ~resync & (wr_cnt_q == CNT_W'(FRAME_PTS - 1));
  assign wr_idx     = resync ? '0 : wr_cnt_q;
  assign err_sync_o = err_sync_q;

  assign rd_full_o = full_q[rd_ptr_q];
  assign rd_pt_o   = mem_q[rd_ptr_q][rd_idx_i];
  assign rd_tag_o  = tag_q[rd_ptr_q];

  // Point storage carries no reset; the full flags alone define validity.
  always_ff @(posedge clk) begin
    if (acc) mem_q[wr_ptr_q][wr_idx] <= wr_pt_i;
  end

  always_comb begin
    full_d      = full_q;
    tag_d       = tag_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    wr_cnt_d    = wr_cnt_q;
    frame_cnt_d = frame_cnt_q;
    // Release and commit always target different slots.
    if (rel_i) begin
      full_d[rd_ptr_q] = 1'b0;
      rd_ptr_d         = ~rd_ptr_q;
    end
    if (resync) begin
      wr_cnt_d = CNT_W'(1);
    end else if (commit) begin
      full_d[wr_ptr_q] = 1'b1;
      tag_d[wr_ptr_q]  = frame_cnt_q;
      frame_cnt_d      = frame_cnt_q + TAG_W'(1);
      wr_ptr_d         = ~wr_ptr_q;
      wr_cnt_d         = '0;
    end else if (acc) begin
      wr_cnt_d = wr_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q      <= '0;
      tag_q       <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      wr_cnt_q    <= '0;
      frame_cnt_q <= '0;
      err_sync_q  <= 1'b0;
    end else begin
      full_q      <= full_d;
      tag_q       <= tag_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_cnt_q    <= wr_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      err_sync_q  <= resync;
    end
  end
endmodule

// File: rtl/geofence_feeder.sv
// Streams buffered 6-point frames into geofence inside its capture window and returns tagged verdicts.
module geofence_feeder
  import geofence_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int TAG_W   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sof,
  input  logic [PT_X_W-1:0] in_x,
  input  logic [PT_Y_W-1:0] in_y,
  input  logic [PT_R_W-1:0] in_r,
  output logic              gf_rst,
  output logic [PT_X_W-1:0] gf_x,
  output logic [PT_Y_W-1:0] gf_y,
  output logic [PT_R_W-1:0] gf_r,
  input  logic              gf_valid,
  input  logic              gf_is_inside,
  output logic              res_valid,
  output logic              res_inside,
  output logic [TAG_W-1:0]  res_tag,
  output logic              err_sync,
  output logic              err_timeout
);
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d, rd_idx;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             gf_rst_q, gf_rst_d;
  point_t           gf_pt_q, gf_pt_d, in_pt, rd_pt;
  logic             res_valid_q, res_valid_d, res_inside_q, res_inside_d;
  logic [TAG_W-1:0] res_tag_q, res_tag_d, cur_tag_q, cur_tag_d, rd_tag;
  logic             err_tmo_q, err_tmo_d, rd_full, rel, start;

  assign in_pt.x = in_x;
  assign in_pt.y = in_y;
  assign in_pt.r = in_r;
  // Outside STREAM the read port always looks at point 0 of the current read slot.
  assign rd_idx  = (state_q == ST_STREAM && rd_cnt_q != CNT_W'(FRAME_PTS)) ? rd_cnt_q : '0;

  geofence_frame_buf #(.TAG_W(TAG_W)) u_buf (
    .clk       (clk),
    .rst_n     (reset),
    .wr_vld_i  (in_valid),
    .wr_sof_i  (in_sof),
    .wr_pt_i   (in_pt),
    .wr_rdy_o  (in_ready),
    .err_sync_o(err_sync),
    .rel_i     (rel),
    .rd_idx_i  (rd_idx),
    .rd_full_o (rd_full),
    .rd_pt_o   (rd_pt),
    .rd_tag_o  (rd_tag)
  );

  always_comb begin
    state_d      = state_q;
    rd_cnt_d     = rd_cnt_q;
    tmo_d        = tmo_q;
    gf_rst_d     = gf_rst_q;
    gf_pt_d      = gf_pt_q;
    res_valid_d  = 1'b0;
    res_inside_d = res_inside_q;
    res_tag_d    = res_tag_q;
    cur_tag_d    = cur_tag_q;
    err_tmo_d    = 1'b0;
    rel          = 1'b0;
    start        = 1'b0;
    case (state_q)
      ST_HOLD: begin
        gf_rst_d = 1'b1;
        gf_pt_d  = '0;
        start    = rd_full;
      end
      ST_STREAM: begin
        if (rd_cnt_q == CNT_W'(FRAME_PTS)) begin
          rel       = 1'b1;
          cur_tag_d = rd_tag;
          tmo_d     = '0;
          gf_pt_d   = '0;
          state_d   = ST_WAIT;
        end else begin
          gf_pt_d  = rd_pt;
          rd_cnt_d = rd_cnt_q + CNT_W'(1);
        end
      end
      ST_WAIT: begin
        gf_pt_d = '0;
        tmo_d   = tmo_q + TMO_W'(1);
        // A result in the final timeout cycle still counts as a result.
        if (gf_valid) begin
          res_valid_d  = 1'b1;
          res_inside_d = gf_is_inside;
          res_tag_d    = cur_tag_q;
          if (rd_full) begin
            start = 1'b1;
          end else begin
            gf_rst_d = 1'b1;
            state_d  = ST_HOLD;
          end
        end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
          err_tmo_d = 1'b1;
          gf_rst_d  = 1'b1;
          state_d   = ST_HOLD;
        end
      end
      default: state_d = ST_HOLD;
    endcase
    if (start) begin
      gf_rst_d = 1'b0;
      gf_pt_d  = rd_pt;
      rd_cnt_d = CNT_W'(1);
      state_d  = ST_STREAM;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_HOLD;
      rd_cnt_q     <= '0;
      tmo_q        <= '0;
      gf_rst_q     <= 1'b1;
      gf_pt_q      <= '0;
      res_valid_q  <= 1'b0;
      res_inside_q <= 1'b0;
      res_tag_q    <= '0;
      cur_tag_q    <= '0;
      err_tmo_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      rd_cnt_q     <= rd_cnt_d;
      tmo_q        <= tmo_d;
      gf_rst_q     <= gf_rst_d;
      gf_pt_q      <= gf_pt_d;
      res_valid_q  <= res_valid_d;
      res_inside_q <= res_inside_d;
      res_tag_q    <= res_tag_d;
      cur_tag_q    <= cur_tag_d;
      err_tmo_q    <= err_tmo_d;
    end
  end

  assign gf_rst      = gf_rst_q;
  assign gf_x        = gf_pt_q.x;
  assign gf_y        = gf_pt_q.y;
  assign gf_r        = gf_pt_q.r;
  assign res_valid   = res_valid_q;
  assign res_inside  = res_inside_q;
  assign res_tag     = res_tag_q;
  assign err_timeout = err_tmo_q;
endmodule

// File: tb/tb_geofence_feeder.sv
// Randomized and directed bench for geofence_feeder against a queue-based frame model.
module tb_geofence_feeder;
  localparam int TIMEOUT = 255;
  localparam int TAG_W   = 4;

  typedef struct packed { logic [9:0] x; logic [9:0] y; logic [10:0] r; } pt_t;
  typedef struct packed { pt_t [5:0] p; logic [3:0] tag; } frame_t;
  typedef struct packed { logic sof; pt_t p; } hpt_t;

  logic clk = 1'b0, reset = 1'b1;
  logic in_valid = 1'b0, in_sof = 1'b0, gf_valid = 1'b0, gf_is_inside = 1'b0;
  logic [9:0] in_x = '0, in_y = '0;
  logic [10:0] in_r = '0;
  logic in_ready, gf_rst, res_valid, res_inside, err_sync, err_timeout;
  logic [9:0] gf_x, gf_y;
  logic [10:0] gf_r;
  logic [TAG_W-1:0] res_tag;

  always #5 clk = ~clk;

  geofence_feeder #(.TIMEOUT(TIMEOUT), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof),
    .in_x(in_x), .in_y(in_y), .in_r(in_r), .gf_rst(gf_rst), .gf_x(gf_x), .gf_y(gf_y),
    .gf_r(gf_r), .gf_valid(gf_valid), .gf_is_inside(gf_is_inside), .res_valid(res_valid),
    .res_inside(res_inside), .res_tag(res_tag), .err_sync(err_sync), .err_timeout(err_timeout)
  );

  // Model: completed frames awaiting release, the partial frame, and the consumer position.
  frame_t wq[$];
  pt_t    part[$];
  hpt_t   hostq[$];
  int     dlyq[$];
  frame_t cur;
  int     frame_cnt, sidx, wcyc, cur_dly, n_acc, cyc;
  int     gap_pct = 0, force_in = -1;
  logic   e_gf_rst, e_rv, e_ri, e_es, e_et;
  logic [3:0] e_rt;
  pt_t    e_gf;
  int     n_tests = 0, n_fail = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic int rand_dly();
    int r = $urandom_range(0, 19);
    if (r == 0) return 1000;
    if (r == 1) return TIMEOUT;
    return $urandom_range(1, 40);
  endfunction

  task automatic model_reset();
    wq.delete(); part.delete();
    frame_cnt = 0; sidx = -1; wcyc = -1;
    e_gf_rst = 1'b1; e_gf = '0; e_rv = 1'b0; e_ri = 1'b0; e_rt = '0; e_es = 1'b0; e_et = 1'b0;
  endtask

  task automatic model_step();
    logic rdy, acc;
    pt_t p;
    frame_t f;
    rdy = (wq.size() < 2);
    acc = in_valid && rdy;
    e_rv = 1'b0; e_es = 1'b0; e_et = 1'b0;
    if (sidx < 0 && wcyc < 0) begin
      if (wq.size() > 0) begin cur = wq[0]; sidx = 0; e_gf_rst = 1'b0; e_gf = cur.p[0]; end
      else begin e_gf_rst = 1'b1; e_gf = '0; end
    end else if (sidx >= 0) begin
      if (sidx < 5) begin sidx++; e_gf = cur.p[sidx]; end
      else begin
        wq.delete(0); sidx = -1; wcyc = 0; e_gf = '0;
        cur_dly = (dlyq.size() > 0) ? dlyq.pop_front() : rand_dly();
      end
    end else begin
      wcyc++;
      if (gf_valid) begin
        e_rv = 1'b1; e_ri = gf_is_inside; e_rt = cur.tag; wcyc = -1;
        if (wq.size() > 0) begin cur = wq[0]; sidx = 0; e_gf_rst = 1'b0; e_gf = cur.p[0]; end
        else e_gf_rst = 1'b1;
      end else if (wcyc == TIMEOUT) begin
        e_et = 1'b1; e_gf_rst = 1'b1; wcyc = -1;
      end
    end
    if (acc) begin
      n_acc++;
      if (hostq.size() > 0) hostq.delete(0);
      p.x = in_x; p.y = in_y; p.r = in_r;
      if (in_sof && part.size() > 0) begin
        e_es = 1'b1; part.delete(); part.push_back(p);
      end else begin
        part.push_back(p);
        if (part.size() == 6) begin
          for (int i = 0; i < 6; i++) f.p[i] = part[i];
          f.tag = 4'(frame_cnt);
          wq.push_back(f);
          frame_cnt = (frame_cnt + 1) % 16;
          part.delete();
        end
      end
    end
  endtask

  task automatic compare_all();
    chk("in_ready", in_ready, wq.size() < 2);
    chk("gf_rst", gf_rst, e_gf_rst);
    chk("gf_x", gf_x, e_gf.x);
    chk("gf_y", gf_y, e_gf.y);
    chk("gf_r", gf_r, e_gf.r);
    chk("res_valid", res_valid, e_rv);
    chk("res_inside", res_inside, e_ri);
    chk("res_tag", res_tag, e_rt);
    chk("err_sync", err_sync, e_es);
    chk("err_timeout", err_timeout, e_et);
  endtask

  task automatic drive();
    if (hostq.size() > 0 && $urandom_range(0, 99) >= gap_pct) begin
      in_valid = 1'b1; in_sof = hostq[0].sof;
      in_x = hostq[0].p.x; in_y = hostq[0].p.y; in_r = hostq[0].p.r;
    end else begin
      in_valid = 1'b0; in_sof = 1'($urandom_range(0, 1));
      in_x = 10'($urandom); in_y = 10'($urandom); in_r = 11'($urandom);
    end
    if (wcyc >= 0) gf_valid = (wcyc + 1 == cur_dly);
    else gf_valid = ($urandom_range(0, 7) == 0);
    gf_is_inside = (force_in < 0) ? 1'($urandom_range(0, 1)) : 1'(force_in);
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset) model_reset(); else model_step();
    cyc++;
    #1;
    compare_all();
    drive();
  endtask

  task automatic push_frame(input int x0, input int y0, input int r0, input logic sof);
    hpt_t h;
    for (int i = 0; i < 6; i++) begin
      h.sof = (i == 0) ? sof : 1'b0;
      h.p.x = 10'(x0 + i); h.p.y = 10'(y0 + i); h.p.r = 11'(r0 + i);
      hostq.push_back(h);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0; hostq.delete(); dlyq.delete();
    tick(); tick();
    reset = 1'b1; n_acc = 0;
  endtask

  int t0, tr, n_rv, n_et, n_es, tfall, trise;
  int tags[$];
  logic fell, rose, hit;

  initial begin
    cyc = 0; n_acc = 0; cur_dly = 0;
    model_reset();
    #1 reset = 1'b0;
    #1;
    chk("rst_gf_rst", gf_rst, 1);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_gf_x", gf_x, 0);
    tick(); tick();
    reset = 1'b1;

    // 1: single frame, verdict after 30 WAIT cycles
    do_reset(); force_in = 1; dlyq.push_back(30); push_frame(10, 100, 500, 1'b1);
    t0 = -1; tr = -1;
    for (int k = 0; k < 200; k++) begin
      tick();
      if (t0 < 0 && gf_rst == 1'b0) begin t0 = cyc; chk("t1_p0_x", gf_x, 10); end
      if (t0 >= 0 && cyc == t0 + 5) chk("t1_p5_x", gf_x, 15);
      if (res_valid) begin
        tr = cyc; chk("t1_tag", res_tag, 0); chk("t1_inside", res_inside, 1); chk("t1_rst", gf_rst, 1);
      end
    end
    chk("t1_latency", tr - t0, 36);

    // 2: two buffered frames, back-to-back streaming
    do_reset(); force_in = 0; dlyq.push_back(10); dlyq.push_back(10);
    push_frame(20, 0, 0, 1'b1); push_frame(40, 0, 0, 1'b1);
    tags.delete(); hit = 1'b0;
    for (int k = 0; k < 200; k++) begin
      tick();
      if (res_valid) begin
        tags.push_back(int'(res_tag));
        if (!hit) begin hit = 1'b1; chk("t2_b2b_rst", gf_rst, 0); chk("t2_b2b_x", gf_x, 40); end
      end
    end
    chk("t2_nres", tags.size(), 2);
    if (tags.size() == 2) begin chk("t2_tag0", tags[0], 0); chk("t2_tag1", tags[1], 1); end

    // 3: three frames offered, back-pressure while first is in flight
    do_reset(); force_in = -1; gap_pct = 0;
    for (int i = 0; i < 3; i++) begin dlyq.push_back(20); push_frame(100 * i + 1, 7, 9, 1'b1); end
    tags.delete(); fell = 1'b0; rose = 1'b0; t0 = -1; tfall = -1; trise = -1;
    for (int k = 0; k < 300; k++) begin
      tick();
      if (t0 < 0 && gf_rst == 1'b0) t0 = cyc;
      if (!fell && in_ready == 1'b0) begin fell = 1'b1; tfall = cyc; chk("t3_fall_acc", n_acc, 12); end
      if (fell && !rose && in_ready == 1'b1) begin rose = 1'b1; trise = cyc; end
      if (res_valid) tags.push_back(int'(res_tag));
    end
    chk("t3_fall_cyc", tfall - t0, 5);
    chk("t3_rise_cyc", trise - t0, 6);
    chk("t3_nres", tags.size(), 3);
    if (tags.size() == 3) begin
      chk("t3_tag0", tags[0], 0); chk("t3_tag1", tags[1], 1); chk("t3_tag2", tags[2], 2);
    end

    // 4: resync on a mid-frame start-of-frame
    do_reset(); dlyq.push_back(8);
    push_frame(200, 1, 1, 1'b1); hostq = hostq[0:2]; push_frame(300, 2, 2, 1'b1);
    n_es = 0; t0 = -1;
    for (int k = 0; k < 150; k++) begin
      tick();
      if (err_sync) n_es++;
      if (t0 < 0 && gf_rst == 1'b0) begin t0 = cyc; chk("t4_p0_x", gf_x, 300); end
      if (t0 >= 0 && cyc == t0 + 5) chk("t4_p5_x", gf_x, 305);
    end
    chk("t4_nsync", n_es, 1);

    // 5: timeout, then a result exactly in the last WAIT cycle
    do_reset(); dlyq.push_back(1000); dlyq.push_back(TIMEOUT);
    push_frame(50, 3, 3, 1'b1); push_frame(70, 4, 4, 1'b1);
    t0 = -1; n_et = 0; n_rv = 0;
    for (int k = 0; k < 700; k++) begin
      tick();
      if (t0 < 0 && gf_rst == 1'b0) t0 = cyc;
      if (err_timeout) begin n_et++; chk("t5_tmo_cyc", cyc - t0, 261); chk("t5_tmo_rst", gf_rst, 1); end
      if (res_valid) begin n_rv++; chk("t5_tag", res_tag, 1); end
    end
    chk("t5_ntmo", n_et, 1);
    chk("t5_nres", n_rv, 1);

    // 6: reset during point 3 of a stream
    do_reset(); dlyq.push_back(5); push_frame(80, 5, 5, 1'b1); push_frame(90, 6, 6, 1'b1);
    hit = 1'b0;
    for (int k = 0; k < 60 && !hit; k++) begin tick(); if (sidx == 3) hit = 1'b1; end
    chk("t6_reached_p3", hit, 1);
    reset = 1'b0; hostq.delete(); dlyq.delete(); in_valid = 1'b0;
    #1;
    chk("t6_gf_rst", gf_rst, 1); chk("t6_gf_x", gf_x, 0); chk("t6_gf_r", gf_r, 0);
    chk("t6_res_valid", res_valid, 0); chk("t6_res_tag", res_tag, 0);
    chk("t6_err", {err_sync, err_timeout}, 0); chk("t6_in_ready", in_ready, 1);
    model_reset();
    tick();
    reset = 1'b1;
    dlyq.push_back(5); push_frame(110, 8, 8, 1'b1);
    n_rv = 0;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (res_valid) begin n_rv++; chk("t6_tag", res_tag, 0); end
    end
    chk("t6_nres", n_rv, 1);

    // Random traffic with gaps, junk prefixes, missing/late verdicts and ignored gf_valid noise
    do_reset(); gap_pct = 30; force_in = -1;
    for (int k = 0; k < 6000; k++) begin
      if (hostq.size() < 8) begin
        if ($urandom_range(0, 9) == 0) begin
          push_frame($urandom_range(0, 1000), $urandom_range(0, 1000), $urandom_range(0, 2000), 1'b1);
          hostq = hostq[0:$urandom_range(0, 4)];
        end
        push_frame($urandom_range(0, 1000), $urandom_range(0, 1000), $urandom_range(0, 2000),
                   ($urandom_range(0, 9) != 0));
      end
      tick();
    end
    hit = 1'b0;
    for (int k = 0; k < 5000 && !hit; k++) begin
      tick();
      if (hostq.size() == 0 && wq.size() == 0 && sidx < 0 && wcyc < 0) hit = 1'b1;
    end
    chk("drain_done", hit, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
